// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: control-bit positions,
// opcode values, stage type and fetch length.
// Optional feature macro: SAP_SEQ_FAST_FETCH_EN (two-stage fetch).
package sap_pkg;

  // Control word bit positions
  localparam int B_HLT        = 15;
  localparam int B_PC_INC     = 14;
  localparam int B_PC_EN      = 13;
  localparam int B_PC_LOAD    = 12;
  localparam int B_MAR_LOAD   = 11;
  localparam int B_MEM_EN     = 10;
  localparam int B_MEM_WE     = 9;
  localparam int B_IR_LOAD    = 8;
  localparam int B_IR_EN      = 7;
  localparam int B_A_LOAD     = 6;
  localparam int B_A_EN       = 5;
  localparam int B_B_LOAD     = 4;
  localparam int B_ALU_SUB    = 3;
  localparam int B_ALU_EN     = 2;
  localparam int B_OUT_LOAD   = 1;
  localparam int B_FLAGS_LOAD = 0;

  // Defined opcodes; every other code behaves as NOP
  localparam int OP_LDA = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_STA = 3;
  localparam int OP_LDI = 4;
  localparam int OP_JMP = 5;
  localparam int OP_JC  = 6;
  localparam int OP_JZ  = 7;
  localparam int OP_OUT = 14;
  localparam int OP_HLT = 15;

  // Natural stage counter type (T0..T5 fits in three bits)
  typedef logic [2:0] stage_t;

`ifdef SAP_SEQ_FAST_FETCH_EN
  localparam int FETCH_LEN = 2;
`else
  localparam int FETCH_LEN = 3;
`endif

  // Longest instruction (ADD/SUB) has three execute steps
  localparam int MAX_STAGE = FETCH_LEN + 2;

  // Run / halt state of the sequencer
  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode table: (stage, opcode, flags) -> control word,
// end-of-instruction marker and halt request. Stages past the longest
// instruction decode to an all-zero word.
// Optional feature macro: SAP_SEQ_FAST_FETCH_EN (two-stage fetch).
module sap_microcode_rom
  import sap_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int STAGE_W = 3
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [OP_W-1:0]    opcode,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic [15:0]        ctrl,
  output logic               instr_end,
  output logic               is_hlt
);

  logic op_lda, op_add, op_sub, op_sta, op_ldi;
  logic op_jmp, op_jc, op_jz, op_out, op_hlt;
  int   st;
  int   step;

  // Full-width opcode compares against zero-extended constants
  assign op_lda = (opcode == OP_W'(OP_LDA));
  assign op_add = (opcode == OP_W'(OP_ADD));
  assign op_sub = (opcode == OP_W'(OP_SUB));
  assign op_sta = (opcode == OP_W'(OP_STA));
  assign op_ldi = (opcode == OP_W'(OP_LDI));
  assign op_jmp = (opcode == OP_W'(OP_JMP));
  assign op_jc  = (opcode == OP_W'(OP_JC));
  assign op_jz  = (opcode == OP_W'(OP_JZ));
  assign op_out = (opcode == OP_W'(OP_OUT));
  assign op_hlt = (opcode == OP_W'(OP_HLT));

  // Decode the current micro-step into strobes
  always_comb begin
    ctrl      = '0;
    instr_end = 1'b0;
    is_hlt    = 1'b0;
    st        = int'(stage);
    step      = st - FETCH_LEN;

    if (st < FETCH_LEN) begin
`ifdef SAP_SEQ_FAST_FETCH_EN
      if (st == 0) begin
        ctrl[B_PC_EN]    = 1'b1;
        ctrl[B_MAR_LOAD] = 1'b1;
        ctrl[B_PC_INC]   = 1'b1;
      end else begin
        ctrl[B_MEM_EN]  = 1'b1;
        ctrl[B_IR_LOAD] = 1'b1;
      end
`else
      if (st == 0) begin
        ctrl[B_PC_EN]    = 1'b1;
        ctrl[B_MAR_LOAD] = 1'b1;
      end else if (st == 1) begin
        ctrl[B_PC_INC] = 1'b1;
      end else begin
        ctrl[B_MEM_EN]  = 1'b1;
        ctrl[B_IR_LOAD] = 1'b1;
      end
`endif
    end else if (step == 0) begin
      // First execute step: the only one where flags matter
      if (op_lda || op_add || op_sub || op_sta) begin
        ctrl[B_IR_EN]    = 1'b1;
        ctrl[B_MAR_LOAD] = 1'b1;
      end else if (op_ldi) begin
        ctrl[B_IR_EN]  = 1'b1;
        ctrl[B_A_LOAD] = 1'b1;
        instr_end      = 1'b1;
      end else if (op_jmp || (op_jc && flag_c) || (op_jz && flag_z)) begin
        ctrl[B_IR_EN]   = 1'b1;
        ctrl[B_PC_LOAD] = 1'b1;
        instr_end       = 1'b1;
      end else if (op_out) begin
        ctrl[B_A_EN]     = 1'b1;
        ctrl[B_OUT_LOAD] = 1'b1;
        instr_end        = 1'b1;
      end else if (op_hlt) begin
        ctrl[B_HLT] = 1'b1;
        is_hlt      = 1'b1;
      end else begin
        // Untaken conditional jump or NOP: empty step, then fetch
        instr_end = 1'b1;
      end
    end else if (step == 1) begin
      if (op_lda) begin
        ctrl[B_MEM_EN] = 1'b1;
        ctrl[B_A_LOAD] = 1'b1;
        instr_end      = 1'b1;
      end else if (op_add || op_sub) begin
        ctrl[B_MEM_EN] = 1'b1;
        ctrl[B_B_LOAD] = 1'b1;
      end else if (op_sta) begin
        ctrl[B_A_EN]   = 1'b1;
        ctrl[B_MEM_WE] = 1'b1;
        instr_end      = 1'b1;
      end else begin
        // IR changed under a running instruction: return to fetch quietly
        instr_end = 1'b1;
      end
    end else if (step == 2) begin
      if (op_add || op_sub) begin
        ctrl[B_ALU_EN]     = 1'b1;
        ctrl[B_A_LOAD]     = 1'b1;
        ctrl[B_FLAGS_LOAD] = 1'b1;
        ctrl[B_ALU_SUB]    = op_sub;
      end
      instr_end = 1'b1;
    end
  end

endmodule

// File: rtl/sap_sequencer.sv
// SAP control sequencer top: stage counter, sticky halt state and the
// output mux around the microcode table. State advances on the falling
// clock edge so the control word is settled for the datapath rising edge.
// Optional feature macro: SAP_SEQ_FAST_FETCH_EN (two-stage fetch).
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int CW_W    = 16,
  parameter int STAGE_W = $bits(stage_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic [CW_W-1:0]    ctrl,
  output logic [STAGE_W-1:0] stage,
  output logic               instr_end,
  output logic               halted
);

  logic [STAGE_W-1:0] stage_reg;
  seq_state_t         state_reg;
  logic [15:0]        rom_ctrl;
  logic               rom_end;
  logic               rom_hlt;
  logic               stage_bad;

  sap_microcode_rom #(
    .OP_W    (OP_W),
    .STAGE_W (STAGE_W)
  ) u_rom (
    .stage     (stage_reg),
    .opcode    (opcode),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .ctrl      (rom_ctrl),
    .instr_end (rom_end),
    .is_hlt    (rom_hlt)
  );

  // Any stage beyond the longest instruction is a corrupted count
  assign stage_bad = (int'(stage_reg) > MAX_STAGE);

  // Stage counter and halt FSM, falling-edge, reset has top priority
  always_ff @(negedge clk) begin
    if (rst) begin
      stage_reg <= '0;
      state_reg <= SEQ_RUN;
    end else if (state_reg == SEQ_RUN) begin
      if (stage_bad) begin
        stage_reg <= '0;
      end else if (rom_hlt) begin
        // Stage stays on the HLT step while halted
        state_reg <= SEQ_HALT;
      end else if (rom_end) begin
        stage_reg <= '0;
      end else begin
        stage_reg <= stage_reg + STAGE_W'(1);
      end
    end
  end

  // Output mux: halt word overrides, corrupted stages emit nothing
  always_comb begin
    ctrl      = '0;
    instr_end = 1'b0;
    if (state_reg == SEQ_HALT) begin
      ctrl[B_HLT] = 1'b1;
    end else if (!stage_bad) begin
      ctrl[15:0] = rom_ctrl;
      instr_end  = rom_end;
    end
  end

  assign stage  = stage_reg;
  assign halted = (state_reg == SEQ_HALT);

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: directed scenarios followed by
// random opcode/flag/reset traffic, compared against a micro-program table
// model. Optional feature macro: SAP_SEQ_FAST_FETCH_EN.
module tb_sap_sequencer;

  localparam logic [15:0] W_HLT   = 16'h8000;
  localparam logic [15:0] W_PCINC = 16'h4000;
  localparam logic [15:0] W_PCEN  = 16'h2000;
  localparam logic [15:0] W_PCLD  = 16'h1000;
  localparam logic [15:0] W_MARLD = 16'h0800;
  localparam logic [15:0] W_MEMEN = 16'h0400;
  localparam logic [15:0] W_MEMWE = 16'h0200;
  localparam logic [15:0] W_IRLD  = 16'h0100;
  localparam logic [15:0] W_IREN  = 16'h0080;
  localparam logic [15:0] W_ALD   = 16'h0040;
  localparam logic [15:0] W_AEN   = 16'h0020;
  localparam logic [15:0] W_BLD   = 16'h0010;
  localparam logic [15:0] W_SUB   = 16'h0008;
  localparam logic [15:0] W_ALUEN = 16'h0004;
  localparam logic [15:0] W_OUTLD = 16'h0002;
  localparam logic [15:0] W_FLGLD = 16'h0001;

`ifdef SAP_SEQ_FAST_FETCH_EN
  localparam int          NFETCH  = 2;
  localparam logic [15:0] T0_WORD = 16'h6800;
`else
  localparam int          NFETCH  = 3;
  localparam logic [15:0] T0_WORD = 16'h2800;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        flag_z;
  logic        flag_c;
  logic [15:0] ctrl;
  logic [2:0]  stage;
  logic        instr_end;
  logic        halted;

  int vectors;
  int miscompares;

  // Reference model state
  int          m_stage;
  bit          m_halted;
  logic [15:0] prog[$];
  bit          prog_hlt;

  // Last observed outputs, for scenario-level literal checks
  logic [15:0] last_ctrl;
  logic        last_end;
  logic [2:0]  last_stage;
  logic        last_halted;

  sap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .ctrl      (ctrl),
    .stage     (stage),
    .instr_end (instr_end),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Whole instruction as a list of control words, fetch included
  task automatic load_program(input logic [3:0] op, input logic fz, input logic fc);
    prog = {};
    prog_hlt = 1'b0;
`ifdef SAP_SEQ_FAST_FETCH_EN
    prog.push_back(W_PCEN | W_MARLD | W_PCINC);
    prog.push_back(W_MEMEN | W_IRLD);
`else
    prog.push_back(W_PCEN | W_MARLD);
    prog.push_back(W_PCINC);
    prog.push_back(W_MEMEN | W_IRLD);
`endif
    case (op)
      4'd0: begin
        prog.push_back(W_IREN | W_MARLD);
        prog.push_back(W_MEMEN | W_ALD);
      end
      4'd1, 4'd2: begin
        prog.push_back(W_IREN | W_MARLD);
        prog.push_back(W_MEMEN | W_BLD);
        prog.push_back(W_ALUEN | W_ALD | W_FLGLD | ((op == 4'd2) ? W_SUB : 16'h0));
      end
      4'd3: begin
        prog.push_back(W_IREN | W_MARLD);
        prog.push_back(W_AEN | W_MEMWE);
      end
      4'd4:  prog.push_back(W_IREN | W_ALD);
      4'd5:  prog.push_back(W_IREN | W_PCLD);
      4'd6:  prog.push_back(fc ? (W_IREN | W_PCLD) : 16'h0);
      4'd7:  prog.push_back(fz ? (W_IREN | W_PCLD) : 16'h0);
      4'd14: prog.push_back(W_AEN | W_OUTLD);
      4'd15: begin
        prog.push_back(W_HLT);
        prog_hlt = 1'b1;
      end
      default: prog.push_back(16'h0);
    endcase
  endtask

  // One clock: drive inputs, compare against the model, advance the model
  task automatic cycle(input logic [3:0] op, input logic fz, input logic fc, input logic r);
    logic [15:0] e_ctrl;
    logic        e_end;
    int          len;
    @(posedge clk);
    #1;
    opcode = op;
    flag_z = fz;
    flag_c = fc;
    rst    = r;
    #1;
    load_program(op, fz, fc);
    len = prog.size();
    if (m_halted) begin
      e_ctrl = W_HLT;
      e_end  = 1'b0;
    end else begin
      e_ctrl = (m_stage < len) ? prog[m_stage] : 16'h0;
      e_end  = !prog_hlt && (m_stage == len - 1);
    end
    chk("ctrl", 32'(ctrl), 32'(e_ctrl));
    chk("instr_end", 32'(instr_end), 32'(e_end));
    chk("stage", 32'(stage), 32'(m_stage));
    chk("halted", 32'(halted), 32'(m_halted));
    last_ctrl   = ctrl;
    last_end    = instr_end;
    last_stage  = stage;
    last_halted = halted;
    if (r)
      $display("[%0t] reset  op=%0d stage=%0d", $time, op, m_stage);
    else if (e_end)
      $display("[%0t] retire op=%0d ctrl=%h", $time, op, ctrl);
    else if (!m_halted && prog_hlt && m_stage == len - 1)
      $display("[%0t] halt   op=%0d ctrl=%h", $time, op, ctrl);
    if (r) begin
      m_stage  = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_stage = m_stage;
    end else if (prog_hlt && m_stage == len - 1) begin
      m_halted = 1'b1;
    end else if (e_end) begin
      m_stage = 0;
    end else begin
      m_stage++;
    end
  endtask

  // Run one complete instruction from stage 0, bounded
  task automatic run_instr(input logic [3:0] op, input logic fz, input logic fc);
    int n;
    n = 0;
    do begin
      cycle(op, fz, fc, 1'b0);
      n++;
    end while (!last_end && n < 10);
    chk("run_bound", 32'(last_end), 32'd1);
  endtask

  initial begin
    logic [3:0] rop;
    logic       r;
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    opcode = 4'd0;
    flag_z = 1'b0;
    flag_c = 1'b0;
    repeat (3) @(posedge clk);
    m_stage  = 0;
    m_halted = 1'b0;
    rop      = 4'd0;

    // Reset state, with rst still held
    cycle(4'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_t0_word", 32'(last_ctrl), 32'(T0_WORD));

    // LDA
    run_instr(4'd0, 1'b0, 1'b0);
    chk("lda_last_word", 32'(last_ctrl), 32'h0440);
    chk("lda_last_stage", 32'(last_stage), 32'(NFETCH + 1));
    cycle(4'd0, 1'b0, 1'b0, 1'b0);
    chk("lda_return_t0", 32'(last_stage), 32'd0);
    run_instr(4'd0, 1'b0, 1'b0);

    // SUB
    run_instr(4'd2, 1'b0, 1'b0);
    chk("sub_last_word", 32'(last_ctrl), 32'h004D);
    chk("sub_last_stage", 32'(last_stage), 32'(NFETCH + 2));

    // JZ taken / not taken
    run_instr(4'd7, 1'b1, 1'b0);
    chk("jz_taken", 32'(last_ctrl), 32'h1080);
    run_instr(4'd7, 1'b0, 1'b1);
    chk("jz_untaken", 32'(last_ctrl), 32'h0000);

    // JC taken with only carry set
    run_instr(4'd6, 1'b0, 1'b1);
    chk("jc_taken", 32'(last_ctrl), 32'h1080);

    // HLT: sticky for 20 cycles, only reset clears it
    repeat (NFETCH + 1) cycle(4'd15, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle(4'd15, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
    chk("hlt_word", 32'(last_ctrl), 32'h8000);
    chk("hlt_flag", 32'(last_halted), 32'd1);
    chk("hlt_stage", 32'(last_stage), 32'(NFETCH));
    cycle(4'd15, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b0, 1'b0);
    chk("hlt_cleared_word", 32'(last_ctrl), 32'(T0_WORD));
    chk("hlt_cleared_flag", 32'(last_halted), 32'd0);
    run_instr(4'd0, 1'b0, 1'b0);

    // Reset in the middle of ADD (on the B_LOAD step)
    repeat (NFETCH + 1) cycle(4'd1, 1'b0, 1'b0, 1'b0);
    cycle(4'd1, 1'b0, 1'b0, 1'b1);
    cycle(4'd1, 1'b0, 1'b0, 1'b0);
    chk("add_abort_stage", 32'(last_stage), 32'd0);
    chk("add_abort_no_ab", 32'(last_ctrl & (W_ALD | W_BLD)), 32'd0);
    run_instr(4'd1, 1'b0, 1'b0);

    // Undefined opcode behaves as NOP
    run_instr(4'd9, 1'b1, 1'b1);
    chk("nop_word", 32'(last_ctrl), 32'd0);
    chk("nop_stage", 32'(last_stage), 32'(NFETCH));

    // Random traffic; opcode only changes between instructions
    for (int i = 0; i < 800; i++) begin
      if (m_stage == 0 && !m_halted)
        rop = 4'($urandom_range(0, 15));
      if (m_halted)
        r = ($urandom_range(0, 3) == 0);
      else
        r = ($urandom_range(0, 31) == 0);
      cycle(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
- Parametrised successor to the SAP control sequencer.
- Generates the per-T-state control word for the bus-based SAP datapath from the IR opcode and ALU flags.
- Adds variable-length instructions with early return to fetch, store/immediate/jump/output opcodes, flag-conditional jumps and a sticky halt state.
- Sits between IR/flags registers and every datapath load/enable strobe.

Parameters:
- OP_W, 4: opcode width. Opcodes are compared as full OP_W values against zero-extended constants. Must be >= 4.
- CW_W, 16: control word width. Bits above 15 are driven 0. Must be >= 16.
- STAGE_W, 3: stage counter width. Must hold 0..5.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  OP_W  IR opcode field; only meaningful from stage 3 onward
- flag_z  in  1  zero flag from flags register
- flag_c  in  1  carry flag from flags register
- ctrl  out  CW_W  control word for the current stage
- stage  out  STAGE_W  current T-state
- instr_end  out  1  high during the last micro-step of the current instruction
- halted  out  1  sticky halt indicator

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The stage/halt registers update on the falling edge of clk, so ctrl is stable for the datapath rising edge. rst is sampled on that same falling edge.
- Reset values: stage=0, halted=0. ctrl is combinational, so it equals the T0 fetch word immediately after reset, and instr_end=0.
- Control bit indices: HLT15 PC_INC14 PC_EN13 PC_LOAD12 MAR_LOAD11 MEM_EN10 MEM_WE9 IR_LOAD8 IR_EN7 A_LOAD6 A_EN5 B_LOAD4 ALU_SUB3 ALU_EN2 OUT_LOAD1 FLAGS_LOAD0.
- Opcodes: LDA=0 ADD=1 SUB=2 STA=3 LDI=4 JMP=5 JC=6 JZ=7 OUT=14 HLT=15. All other codes are NOP.
- Fetch (all opcodes):
  - T0: PC_EN, MAR_LOAD.
  - T1: PC_INC.
  - T2: MEM_EN, IR_LOAD.
- Execute (the instruction ends at the stage marked "end"):
  - LDA: T3 IR_EN, MAR_LOAD; T4 MEM_EN, A_LOAD, end.
  - ADD: T3 IR_EN, MAR_LOAD; T4 MEM_EN, B_LOAD; T5 ALU_EN, A_LOAD, FLAGS_LOAD, end.
  - SUB: same as ADD, plus ALU_SUB at T5.
  - STA: T3 IR_EN, MAR_LOAD; T4 A_EN, MEM_WE, end.
  - LDI: T3 IR_EN, A_LOAD, end.
  - JMP: T3 IR_EN, PC_LOAD, end.
  - JC: T3 IR_EN, PC_LOAD only if flag_c=1; end regardless.
  - JZ: same as JC, using flag_z.
  - OUT: T3 A_EN, OUT_LOAD, end.
  - NOP/undefined: T3 all-zero, end.
- Sequencing:
  - With instr_end=1, the next edge sets stage=0; otherwise stage increments.
  - Stage never exceeds 5. If stage is ever 6 or 7, the next edge sets stage=0 and ctrl=0.
  - Flags are sampled combinationally during T3 only.
- Halt:
  - HLT at T3 drives ctrl=HLT bit only. The next edge sets halted=1 and holds stage at 3.
  - While halted: ctrl=HLT bit only, instr_end=0.
  - Only rst leaves the halted state.
- Reset priority: rst wins over any stage or halt state, including reset mid-instruction. The aborted instruction's remaining strobes are never issued.

Optional Feature:
- Macro: SAP_SEQ_FAST_FETCH_EN.
- Defined: fetch is two stages.
  - T0: PC_EN, MAR_LOAD, PC_INC (the PC counter must tolerate a same-cycle increment after output).
  - T1: MEM_EN, IR_LOAD.
  - Every execute step shifts down one stage (LDA ends at T3, ADD/SUB end at T4). Max stage is 4.
  - HLT holds stage at 2.
- Undefined: three-stage fetch as above.

Decomposition:
- Package sap_pkg holds:
  - control-bit index localparams;
  - opcode localparams;
  - the stage typedef;
  - FETCH_LEN, set to 3 or 2 according to the macro.
- Sub-module sap_microcode_rom: purely combinational (stage, opcode, flag_z, flag_c) -> (ctrl, instr_end, is_hlt).
- sap_sequencer keeps only the stage counter, halt register and output muxing.

Test Plan:
- Reset then LDA (opcode=0):
  - ctrl = 0x2800, 0x4000, 0x0500, 0x0880, 0x0440 across T0..T4;
  - instr_end=1 at T4 only;
  - stage returns to 0 next edge.
- SUB (opcode=2): T5 ctrl=0x004D; stage sequence 0,1,2,3,4,5,0.
- JZ (opcode=7):
  - flag_z=1: T3 ctrl=0x1080;
  - flag_z=0: T3 ctrl=0x0000;
  - both cases return to stage 0 after T3.
- HLT (opcode=15):
  - ctrl=0x8000 and halted=1 persist for 20 cycles with stage=3;
  - asserting rst gives stage=0, halted=0, ctrl=0x2800.
- rst asserted at ADD T4: next edge stage=0; no B_LOAD or A_LOAD strobes issued afterwards.
- Undefined opcode=9: T3 ctrl=0, instr_end=1. With SAP_SEQ_FAST_FETCH_EN, rerun LDA and check the T3 end and T0 ctrl=0x6800.
